// File: rtl/sysbus_pkg.sv
// Shared sysbus definitions: writeback FSM states, write-memory tag and sizing helper.
// The SYSBUS_* macros get fallback encodings when the surrounding build does not define them.
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

package sysbus_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArb,
      StAddr,
      StData,
      StEnd
   } sb_state_e;

   localparam int unsigned SysbusWrMemTag =
      (32'(`SYSBUS_WRITE) << 12) | (32'(`SYSBUS_MEMORY) << 8);

   // Index width that stays legal when only a single slot or beat exists.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/line_fifo.sv
// Small synchronous FIFO holding pending {address, line} writeback entries.
module line_fifo
   import sysbus_pkg::*;
#(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = clog2_min1(Depth);
   localparam int unsigned CntW = $clog2(Depth) + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   // A full queue may still take a push when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/store_line_writer.sv
// Cache-line writeback engine: queues line writes, wins the sysbus, sends address then BEATS beats.
// Optional completed-line counter enabled by defining STORE_LINE_WRITER_COUNT_EN.
module store_line_writer
   import sysbus_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned LINE_BYTES     = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned QUEUE_DEPTH    = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      wb_valid_i,
   output logic                      wb_ready_o,
   input  logic [BUS_DATA_WIDTH-1:0] wb_addr_i,
   input  logic [LINE_BYTES*8-1:0]   wb_data_i,
   output logic                      wb_done_o,
   output logic                      abtr_reqcyc_o,
   input  logic                      abtr_grant_i,
   output logic                      bus_busy_o,
   output logic                      main_bus_reqcyc_o,
   input  logic                      main_bus_reqack_i,
   output logic [BUS_DATA_WIDTH-1:0] main_bus_req_o,
   output logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag_o,
   input  logic                      main_bus_respcyc_i,
   output logic                      main_bus_respack_o,
   output logic [31:0]               wb_count_o
);

   localparam int unsigned LineW  = LINE_BYTES * 8;
   localparam int unsigned Beats  = LineW / BUS_DATA_WIDTH;
   localparam int unsigned BeatW  = clog2_min1(Beats);
   localparam int unsigned EntryW = BUS_DATA_WIDTH + LineW;

   localparam logic [BUS_DATA_WIDTH-1:0] AddrMask = ~(BUS_DATA_WIDTH'(LINE_BYTES - 1));
   localparam logic [BUS_TAG_WIDTH-1:0]  WrMemTag = BUS_TAG_WIDTH'(SysbusWrMemTag);

   logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [EntryW-1:0]         fifo_rdata;
   logic [BUS_DATA_WIDTH-1:0] head_addr;
   logic [LineW-1:0]          head_data;

   sb_state_e                 state_q;
   logic [BeatW-1:0]          beat_q;
   logic                      abtr_reqcyc_q, bus_busy_q, reqcyc_q, wb_done_q;
   logic [BUS_DATA_WIDTH-1:0] req_q;
   logic [BUS_TAG_WIDTH-1:0]  tag_q;
   logic                      unused_respcyc;

   assign unused_respcyc = main_bus_respcyc_i;

   assign wb_ready_o = !fifo_full;
   assign fifo_push  = wb_valid_i && !fifo_full;
   assign fifo_pop   = (state_q == StData) && (beat_q == BeatW'(Beats - 1));
   assign head_addr  = fifo_rdata[EntryW-1 -: BUS_DATA_WIDTH];
   assign head_data  = fifo_rdata[LineW-1:0];

   line_fifo #(
      .Width (EntryW),
      .Depth (QUEUE_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .wdata_i ({wb_addr_i, wb_data_i}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   function automatic logic [BUS_DATA_WIDTH-1:0] beat_slice(input logic [LineW-1:0] line,
                                                           input logic [BeatW-1:0] idx);
      return line[int'(idx)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
   endfunction

   // Outputs are registered alongside the state, so each is loaded on entry to the state it serves.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         beat_q        <= '0;
         abtr_reqcyc_q <= 1'b0;
         bus_busy_q    <= 1'b0;
         reqcyc_q      <= 1'b0;
         wb_done_q     <= 1'b0;
         req_q         <= '0;
         tag_q         <= '0;
      end else begin
         wb_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty || fifo_push) begin
                  state_q       <= StArb;
                  abtr_reqcyc_q <= 1'b1;
               end
            end
            StArb: begin
               if (abtr_grant_i) begin
                  state_q       <= StAddr;
                  abtr_reqcyc_q <= 1'b0;
                  bus_busy_q    <= 1'b1;
                  reqcyc_q      <= 1'b1;
                  req_q         <= head_addr & AddrMask;
                  tag_q         <= WrMemTag;
               end
            end
            StAddr: begin
               if (main_bus_reqack_i) begin
                  state_q <= StData;
                  beat_q  <= '0;
                  req_q   <= beat_slice(head_data, '0);
               end
            end
            StData: begin
               if (fifo_pop) begin
                  state_q   <= StEnd;
                  reqcyc_q  <= 1'b0;
                  req_q     <= '0;
                  tag_q     <= '0;
                  wb_done_q <= 1'b1;
               end else begin
                  beat_q <= beat_q + 1'b1;
                  req_q  <= beat_slice(head_data, beat_q + 1'b1);
               end
            end
            StEnd: begin
               bus_busy_q <= 1'b0;
               if (!fifo_empty || fifo_push) begin
                  state_q       <= StArb;
                  abtr_reqcyc_q <= 1'b1;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign abtr_reqcyc_o      = abtr_reqcyc_q;
   assign bus_busy_o         = bus_busy_q;
   assign main_bus_reqcyc_o  = reqcyc_q;
   assign main_bus_req_o     = req_q;
   assign main_bus_reqtag_o  = tag_q;
   assign main_bus_respack_o = 1'b0;
   assign wb_done_o          = wb_done_q;

`ifdef STORE_LINE_WRITER_COUNT_EN
   logic [31:0] wb_count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_count_q <= '0;
      end else if (wb_done_q) begin
         wb_count_q <= wb_count_q + 32'd1;
      end
   end

   assign wb_count_o = wb_count_q;
`else
   assign wb_count_o = '0;
`endif

endmodule

// File: tb/tb_store_line_writer.sv
// Self-checking bench: directed latency table, back-to-back, reset abort, random traffic, wide bus.
module tb_store_line_writer;

   localparam int W = 64;
   localparam int LB = 64;
   localparam int BEATS = LB * 8 / W;
   localparam int D = 2;
   localparam logic [12:0] TagWrMem = 13'h0100;
`ifdef STORE_LINE_WRITER_COUNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   localparam int PhIdle = 0, PhArb = 1, PhAddr = 2, PhData = 3, PhEnd = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wb_valid = 1'b0, abtr_grant = 1'b0, reqack = 1'b0;
   logic [63:0]   wb_addr = '0;
   logic [511:0]  wb_data = '0;
   logic          wb_ready, wb_done, abtr_reqcyc, bus_busy, reqcyc, respack;
   logic [63:0]   req;
   logic [12:0]   reqtag;
   logic [31:0]   wb_count;

   logic          b_valid = 1'b0, b_grant = 1'b0, b_ack = 1'b0;
   logic [127:0]  b_addr = '0;
   logic [255:0]  b_data = '0;
   logic          b_ready, b_done, b_abtr, b_busy, b_reqcyc, b_respack;
   logic [127:0]  b_req;
   logic [12:0]   b_tag;
   logic [31:0]   b_count;

   always #5 clk = ~clk;

   store_line_writer u_dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .wb_valid_i         (wb_valid),
      .wb_ready_o         (wb_ready),
      .wb_addr_i          (wb_addr),
      .wb_data_i          (wb_data),
      .wb_done_o          (wb_done),
      .abtr_reqcyc_o      (abtr_reqcyc),
      .abtr_grant_i       (abtr_grant),
      .bus_busy_o         (bus_busy),
      .main_bus_reqcyc_o  (reqcyc),
      .main_bus_reqack_i  (reqack),
      .main_bus_req_o     (req),
      .main_bus_reqtag_o  (reqtag),
      .main_bus_respcyc_i (1'b0),
      .main_bus_respack_o (respack),
      .wb_count_o         (wb_count)
   );

   store_line_writer #(
      .BUS_DATA_WIDTH (128),
      .LINE_BYTES     (32)
   ) u_dut_w (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .wb_valid_i         (b_valid),
      .wb_ready_o         (b_ready),
      .wb_addr_i          (b_addr),
      .wb_data_i          (b_data),
      .wb_done_o          (b_done),
      .abtr_reqcyc_o      (b_abtr),
      .abtr_grant_i       (b_grant),
      .bus_busy_o         (b_busy),
      .main_bus_reqcyc_o  (b_reqcyc),
      .main_bus_reqack_i  (b_ack),
      .main_bus_req_o     (b_req),
      .main_bus_reqtag_o  (b_tag),
      .main_bus_respcyc_i (1'b1),
      .main_bus_respack_o (b_respack),
      .wb_count_o         (b_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: queue of accepted lines plus the bus phase the protocol should be in.
   typedef struct {
      logic [63:0]  addr;
      logic [511:0] data;
   } line_t;

   line_t       mq[$];
   int          ph = PhIdle;
   int          mbeat = 0;
   int          mcnt = 0;
   int          n_done = 0;
   int          n_push = 0;
   bit          saw_done;
   bit          last_push;
   logic [63:0] seen_addr;

   function automatic logic [511:0] rnd_line();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [63:0] rnd_addr();
      return {$urandom, $urandom};
   endfunction

   task automatic step(input bit v, input logic [63:0] ad, input logic [511:0] dt,
                       input bit g, input bit a);
      logic [63:0] e_req;
      bit          e_rdy, e_cyc, push;
      @(negedge clk);
      e_rdy = mq.size() < D;
      e_cyc = (ph == PhAddr) || (ph == PhData);
      e_req = '0;
      if (ph == PhAddr) e_req = mq[0].addr & ~64'(LB - 1);
      if (ph == PhData) e_req = 64'(mq[0].data >> (mbeat * W));
      check("wb_ready", wb_ready, e_rdy);
      check("abtr_reqcyc", abtr_reqcyc, ph == PhArb);
      check("reqcyc", reqcyc, e_cyc);
      check("bus_busy", bus_busy, e_cyc || ph == PhEnd);
      check("wb_done", wb_done, ph == PhEnd);
      check("req", req, e_req);
      check("reqtag", reqtag, e_cyc ? TagWrMem : 13'h0);
      check("wb_count", wb_count, mcnt);
      check("respack", respack, 1'b0);
      if (ph == PhAddr) seen_addr = req;
      if (ph == PhEnd) begin
         saw_done = 1'b1;
         n_done++;
      end
      wb_valid   = v;
      wb_addr    = ad;
      wb_data    = dt;
      abtr_grant = g;
      reqack     = a;
      push       = v && e_rdy;
      last_push  = push;
      case (ph)
         PhIdle: if (mq.size() > 0 || push) ph = PhArb;
         PhArb:  if (g) ph = PhAddr;
         PhAddr: if (a) begin ph = PhData; mbeat = 0; end
         PhData: begin
            if (mbeat == BEATS - 1) begin
               ph = PhEnd;
               void'(mq.pop_front());
            end else begin
               mbeat++;
            end
         end
         default: begin
            if (CntEn) mcnt++;
            ph = (mq.size() > 0 || push) ? PhArb : PhIdle;
         end
      endcase
      if (push) begin
         mq.push_back('{addr: ad, data: dt});
         n_push++;
      end
   endtask

   typedef struct {
      logic [63:0] addr;
      int          gd;
      int          ad;
      bit          spurious;
      logic [63:0] exp_addr;
      int          exp_done;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t vc, input string name);
      int done_t = -1;
      bit g, a;
      saw_done = 1'b0;
      for (int t = 0; t < 60; t++) begin
         g = (t == 1 + vc.gd) || (vc.spurious && t == 0);
         a = (t == 2 + vc.gd + vc.ad) || (vc.spurious && t < 2 + vc.gd);
         step(t == 0, (t == 0) ? vc.addr : rnd_addr(), rnd_line(), g, a);
         if (saw_done) begin
            done_t = t;
            break;
         end
      end
      check({name, "_done_cycle"}, done_t, vc.exp_done);
      check({name, "_addr_beat"}, seen_addr, vc.exp_addr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t3, d0, p0;
      logic [127:0] sa;
      logic [255:0] sd;

      vecs[0] = '{64'h0000_0000_1000_0047, 0, 0, 1'b0, 64'h0000_0000_1000_0040, 11};
      vecs[1] = '{64'h0000_0000_2000_00FF, 0, 3, 1'b0, 64'h0000_0000_2000_00C0, 14};
      vecs[2] = '{64'hDEAD_BEEF_0000_1234, 5, 0, 1'b0, 64'hDEAD_BEEF_0000_1200, 16};
      vecs[3] = '{64'h0000_0000_0000_0007, 2, 2, 1'b1, 64'h0000_0000_0000_0000, 15};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 13};

      #12;
      check("reset_ready", wb_ready, 1'b1);
      check("reset_outs", {abtr_reqcyc, bus_busy, reqcyc, wb_done, req, reqtag, wb_count},
            '0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Three back-to-back pushes into a two-deep queue.
      t3 = -1;
      d0 = n_done;
      p0 = n_push;
      for (int t = 0; t < 80; t++) begin
         step((n_push - p0) < 3, rnd_addr(), rnd_line(), 1'b1, 1'b1);
         if (last_push && (n_push - p0) == 3) t3 = t;
         if (n_done - d0 == 3 && ph == PhIdle) break;
      end
      check("b2b_third_push_cycle", t3, 11);
      check("b2b_done_count", n_done - d0, 3);

      // Abort during beat 4 with an asynchronous reset.
      for (int t = 0; t < 8; t++) step(t == 0, rnd_addr(), rnd_line(), 1'b1, 1'b1);
      check("pre_reset_in_data", reqcyc, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outs", {abtr_reqcyc, bus_busy, reqcyc, wb_done, req, reqtag, wb_count},
            '0);
      check("async_reset_ready", wb_ready, 1'b1);
      mq.delete();
      ph = PhIdle;
      mcnt = 0;
      wb_valid = 1'b0;
      abtr_grant = 1'b0;
      reqack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 3; t++) step(1'b0, rnd_addr(), rnd_line(), 1'b1, 1'b1);
      run_vec(vecs[0], "post_reset");

      // Random traffic with random grant and reqack, then drain.
      d0 = n_done;
      p0 = n_push;
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 2) == 0, rnd_addr(), rnd_line(),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      for (int i = 0; i < 300 && (mq.size() > 0 || ph != PhIdle); i++)
         step(1'b0, rnd_addr(), rnd_line(), 1'b1, 1'b1);
      check("random_drained", (mq.size() == 0 && ph == PhIdle), 1'b1);
      check("random_done_vs_push", n_done - d0, n_push - p0);
      wb_valid = 1'b0;

      // Wide-bus instance: two 128-bit beats per 32-byte line.
      sa = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_333F;
      for (int k = 0; k < 8; k++) sd[k*32 +: 32] = $urandom;
      @(negedge clk);
      check("w_ready", b_ready, 1'b1);
      b_valid = 1'b1; b_addr = sa; b_data = sd; b_grant = 1'b1; b_ack = 1'b1;
      @(negedge clk);
      b_valid = 1'b0; b_addr = ~sa; b_data = ~sd;
      check("w_arb", b_abtr, 1'b1);
      @(negedge clk);
      check("w_addr", {b_reqcyc, b_req}, {1'b1, sa & ~128'h1F});
      check("w_tag", b_tag, TagWrMem);
      @(negedge clk);
      check("w_beat0", {b_reqcyc, b_req}, {1'b1, sd[127:0]});
      @(negedge clk);
      check("w_beat1", {b_reqcyc, b_req}, {1'b1, sd[255:128]});
      @(negedge clk);
      check("w_done", {b_done, b_busy, b_reqcyc}, 3'b110);
      @(negedge clk);
      check("w_after", {b_done, b_busy, b_abtr, b_respack}, 4'b0000);
      check("w_count", b_count, CntEn ? 32'd1 : 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
